// File: rtl/lcd_refresh_sequencer.sv
// lcd_refresh_sequencer: HD44780 8-bit write-only driver.
// Power-up wait, init commands, then 2x16 repaint from a char source.
module lcd_refresh_sequencer #(
  parameter int T_POWERUP = 1875000,
  parameter int T_SETUP   = 8,
  parameter int T_EN_HIGH = 32,
  parameter int T_CMD     = 5000,
  parameter int T_CLEAR   = 200000,
  parameter int CNT_W     = 24
) (
  input  logic       SYS_clk,
  input  logic       SYS_reset_n,
  input  logic       refresh_req,
  input  logic [7:0] char_data,
  output logic [4:0] char_addr,
  output logic       busy,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  typedef enum logic [1:0] {
    S_POWERUP, S_INIT, S_REFRESH, S_IDLE
  } top_e;

  typedef enum logic [1:0] {
    P_SETUP, P_PULSE, P_WAIT
  } ph_e;

  localparam logic [CNT_W-1:0] C_PWR = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] C_SET = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] C_EN  = CNT_W'(T_EN_HIGH - 1);
  localparam logic [CNT_W-1:0] C_CMD = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] C_CLR = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ZRO = '0;

  localparam logic [5:0] LAST_INIT = 6'd3;
  localparam logic [5:0] LAST_REF  = 6'd33;
  localparam logic [5:0] IDX_L2    = 6'd17;

  top_e             top_q, top_d;
  ph_e              ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic [4:0]       addr_q, addr_d;
  logic             start;
  logic             is_clear;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    case (i)
      2'd0:    c = 8'h38;
      2'd1:    c = 8'h06;
      2'd2:    c = 8'h0C;
      default: c = 8'h01;
    endcase
    return c;
  endfunction

  assign is_clear = !rs_q && (data_q == 8'h01);

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      top_q  <= S_POWERUP;
      ph_q   <= P_SETUP;
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
      rs_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      top_q  <= top_d;
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      done_q <= done_d;
      data_q <= data_d;
      rs_q   <= rs_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    top_d  = top_q;
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    pend_d = pend_q;
    done_d = done_q;
    data_d = data_q;
    rs_d   = rs_q;
    addr_d = addr_q;
    start  = 1'b0;
    if (refresh_req && done_q && (top_q != S_IDLE))
      pend_d = 1'b1;
    case (top_q)
      S_POWERUP: begin
        if (cnt_q == C_PWR) begin
          top_d = S_INIT;
          idx_d = '0;
          start = 1'b1;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_IDLE: begin
        if (refresh_req || pend_q) begin
          top_d  = S_REFRESH;
          idx_d  = '0;
          pend_d = 1'b0;
          start  = 1'b1;
        end
      end
      default: begin
        case (ph_q)
          P_SETUP: begin
            // Address went out on SETUP entry; latch its char next.
            if (rs_q && (cnt_q == C_SET))
              data_d = char_data;
            if (cnt_q == C_ZRO) begin
              ph_d  = P_PULSE;
              cnt_d = C_EN;
            end else begin
              cnt_d = cnt_q - C_ONE;
            end
          end
          P_PULSE: begin
            if (cnt_q == C_ZRO) begin
              ph_d  = P_WAIT;
              cnt_d = is_clear ? C_CLR : C_CMD;
            end else begin
              cnt_d = cnt_q - C_ONE;
            end
          end
          default: begin
            if (cnt_q != C_ZRO) begin
              cnt_d = cnt_q - C_ONE;
            end else if (top_q == S_INIT && idx_q == LAST_INIT) begin
              done_d = 1'b1;
              top_d  = S_REFRESH;
              idx_d  = '0;
              start  = 1'b1;
            end else if (top_q == S_REFRESH && idx_q == LAST_REF) begin
              top_d = S_IDLE;
            end else begin
              idx_d = idx_q + 6'd1;
              start = 1'b1;
            end
          end
        endcase
      end
    endcase
    if (start) begin
      ph_d  = P_SETUP;
      cnt_d = C_SET;
      if (top_d == S_INIT) begin
        rs_d   = 1'b0;
        data_d = init_cmd(idx_d[1:0]);
      end else if (idx_d == 6'd0) begin
        rs_d   = 1'b0;
        data_d = 8'h80;
      end else if (idx_d == IDX_L2) begin
        rs_d   = 1'b0;
        data_d = 8'hC0;
      end else begin
        rs_d   = 1'b1;
        addr_d = (idx_d < IDX_L2) ? 5'(idx_d - 6'd1)
                                  : 5'(idx_d - 6'd2);
      end
    end
  end

  always_comb begin
    lcd_en = ((top_q == S_INIT) || (top_q == S_REFRESH))
             && (ph_q == P_PULSE);
    busy   = (top_q != S_IDLE);
    lcd_rw = 1'b0;
  end

  assign lcd_data  = data_q;
  assign lcd_rs    = rs_q;
  assign char_addr = addr_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// tb_lcd_refresh_sequencer: directed stimulus with expected-transfer
// queue; a negedge monitor pops one entry per EN pulse.
module tb_lcd_refresh_sequencer;

  localparam int TPU = 10;
  localparam int TS  = 2;
  localparam int TEH = 3;
  localparam int TC  = 4;
  localparam int TCL = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [7:0] char_data;
  logic [4:0] char_addr;
  logic       busy, init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] addr;
    int         gap;
  } xfer_t;

  xfer_t q[$];

  always #5 clk = ~clk;

  assign char_data = 8'h41 + {3'b000, char_addr};

  lcd_refresh_sequencer #(
    .T_POWERUP(TPU), .T_SETUP(TS), .T_EN_HIGH(TEH),
    .T_CMD(TC), .T_CLEAR(TCL), .CNT_W(24)
  ) dut (
    .SYS_clk(clk),
    .SYS_reset_n(rst_n),
    .refresh_req(req),
    .char_data(char_data),
    .char_addr(char_addr),
    .busy(busy),
    .init_done(init_done),
    .lcd_data(lcd_data),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_en(lcd_en)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chk_ge(input string n, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected >= %0d", n, act, min);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] d,
                      input logic [4:0] a, input int gap);
    xfer_t x;
    x.rs = rs; x.data = d; x.addr = a; x.gap = gap;
    q.push_back(x);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, 5'd0, TPU + TS);
    push(1'b0, 8'h06, 5'd0, TS + TEH + TC);
    push(1'b0, 8'h0C, 5'd0, TS + TEH + TC);
    push(1'b0, 8'h01, 5'd0, TS + TEH + TC);
  endtask

  task automatic push_refresh(input int first_gap);
    push(1'b0, 8'h80, 5'd0, first_gap);
    for (int i = 0; i < 16; i++)
      push(1'b1, 8'(8'h41 + i), 5'(i), TS + TEH + TC);
    push(1'b0, 8'hC0, 5'd0, TS + TEH + TC);
    for (int i = 16; i < 32; i++)
      push(1'b1, 8'(8'h41 + i), 5'(i), TS + TEH + TC);
  endtask

  task automatic pulse_req();
    @(negedge clk); #2 req = 1'b1;
    @(negedge clk); #2 req = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string n);
    int k;
    k = 0;
    while ((q.size() != 0 || busy) && k < max) begin
      @(negedge clk); #2;
      k++;
    end
    chk(n, {31'd0, (q.size() == 0 && !busy)}, 32'd1);
    repeat (5) @(negedge clk);
    #2 chk({n, "_stays_idle"}, {31'd0, busy}, 32'd0);
  endtask

  int         cyc, rise_cyc, fall01_cyc, hi_cnt;
  int         stab_rs, stab_d, hold_w;
  logic       have_rise, prev_en, prev_rs, prev_done, rw_bad;
  logic [7:0] prev_d;
  xfer_t      cur;

  initial rw_bad = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; have_rise = 1'b0; prev_en = 1'b0;
      prev_rs = lcd_rs; prev_d = lcd_data; prev_done = 1'b0;
      stab_rs = 0; stab_d = 0; hi_cnt = 0;
      fall01_cyc = 0; hold_w = TC;
    end else begin
      cyc++;
      if (lcd_rw !== 1'b0) rw_bad = 1'b1;
      if (have_rise && (lcd_rs !== prev_rs || lcd_data !== prev_d))
        chk_ge("hold_until_setup", cyc - rise_cyc, TEH + hold_w);
      stab_rs = (lcd_rs === prev_rs) ? stab_rs + 1 : 1;
      stab_d  = (lcd_data === prev_d) ? stab_d + 1 : 1;
      if (lcd_en && !prev_en) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_xfer: got rs=%0b data=%0h expected none",
                   lcd_rs, lcd_data);
        end else begin
          cur = q.pop_front();
          chk("rs", {31'd0, lcd_rs}, {31'd0, cur.rs});
          chk("data", {24'd0, lcd_data}, {24'd0, cur.data});
          if (cur.rs)
            chk("char_addr", {27'd0, char_addr}, {27'd0, cur.addr});
          chk_ge("rs_setup", stab_rs - 1, TS);
          chk_ge("data_setup", stab_d - 1, cur.rs ? TS - 1 : TS);
          if (cur.gap >= 0)
            chk("spacing", have_rise ? cyc - rise_cyc : cyc, cur.gap);
          hold_w = (!cur.rs && cur.data == 8'h01) ? TCL : TC;
        end
        have_rise = 1'b1;
        rise_cyc = cyc;
        hi_cnt = 0;
      end
      if (lcd_en) hi_cnt++;
      if (!lcd_en && prev_en) begin
        chk("pulse_width", hi_cnt, TEH);
        if (!lcd_rs && lcd_data == 8'h01) fall01_cyc = cyc;
      end
      if (init_done && !prev_done)
        chk("init_done_delay", cyc - fall01_cyc, TCL);
      prev_en = lcd_en; prev_rs = lcd_rs;
      prev_d = lcd_data; prev_done = init_done;
    end
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_addr", {27'd0, char_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);

    push_init();
    push_refresh(TS + TEH + TCL);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    pulse_req();
    wait_idle(2000, "init_and_refresh");
    chk("init_done_high", {31'd0, init_done}, 32'd1);

    @(negedge clk); #2;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    push_refresh(-1);
    req = 1'b1;
    @(negedge clk); #2 req = 1'b0;
    chk("busy_after_req", {31'd0, busy}, 32'd1);
    wait_idle(2000, "idle_refresh");

    push_refresh(-1);
    push_refresh(TS + TEH + TC + 1);
    pulse_req();
    repeat (40) @(negedge clk);
    pulse_req();
    repeat (40) @(negedge clk);
    pulse_req();
    repeat (40) @(negedge clk);
    pulse_req();
    wait_idle(3000, "pending_refresh");

    push_refresh(-1);
    pulse_req();
    k = 0;
    while (!(lcd_en && lcd_rs && lcd_data == 8'h46) && k < 1000) begin
      @(negedge clk); #2;
      k++;
    end
    chk("reach_char5", {31'd0, (k < 1000)}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_en", {31'd0, lcd_en}, 32'd0);
    chk("abort_init_done", {31'd0, init_done}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    q.delete();
    repeat (3) @(negedge clk);
    push_init();
    push_refresh(TS + TEH + TCL);
    #2 rst_n = 1'b1;
    wait_idle(2000, "restart_after_abort");

    chk("rw_always_zero", {31'd0, rw_bad}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
